cache_controller: RTL and testbench

Request-sequencing FSM sitting directly upstream of the ACE controller. It accepts one CPU load/store at a time, evaluates the datapath tag-compare result, and either completes the hit locally or issues `read_req`, `write_req` or `invalid_req` to the ACE controller, then waits for `ace_ready`. It also drives the datapath tag/data/state write strobes for store hits, line fills and upgrades.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_perf_counter.sv | 22 ++
 rtl/cache_controller.sv | 158 +++++++++++++++
 tb/tb_cache_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache request sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    // Default width of the hit/miss performance counters.
    localparam int CC_CNT_W = 32;

    // Request sequencer states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        UPGRADE   = 3'd4
    } cc_state_e;

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating event counter with synchronous active-high reset.
// Latency: count visible the cycle after an enabled edge.
// Backpressure: none; holds at all-ones once saturated.
module cache_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count enabled events, stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cache_controller.sv
// CPU request sequencer in front of the ACE controller; optional hit/miss counters under CACHE_PERF_CNT_EN.
// Latency: hits complete 2 cycles after the request; each ACE transaction adds its handshake time (+1 per return to COMPARE).
// Backpressure: one request in flight; CPU request held until cpu_ready, ACE requests held as levels until ace_ready.
module cache_controller
    import cache_pkg::*;
#(
    parameter int CNT_W = CC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req_valid,
    input  logic             cpu_req_wr,
    output logic             cpu_ready,
    input  logic             hit,
    input  logic             line_valid,
    input  logic             line_dirty,
    input  logic             line_shared,
    output logic             read_req,
    output logic             write_req,
    output logic             invalid_req,
    input  logic             ace_ready,
    output logic             tag_we,
    output logic             data_we,
    output logic             fill_sel,
    output logic             state_we,
    output logic             new_dirty,
    output logic             new_shared,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    cc_state_e state_q;
    cc_state_e state_d;
    logic      wr_q;

    // State register; the request type is captured once when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && cpu_req_valid) begin
                wr_q <= cpu_req_wr;
            end
        end
    end

    // Next state, ACE request levels and datapath write strobes.
    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        read_req    = 1'b0;
        write_req   = 1'b0;
        invalid_req = 1'b0;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        fill_sel    = 1'b0;
        state_we    = 1'b0;
        new_dirty   = 1'b0;
        new_shared  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit && !wr_q) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                end else if (hit && !line_shared) begin
                    // Store into a uniquely held line: write CPU data, mark dirty.
                    data_we   = 1'b1;
                    state_we  = 1'b1;
                    new_dirty = 1'b1;
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                end else if (hit) begin
                    // Store into a shared line needs ownership first.
                    state_d = UPGRADE;
                end else if (line_valid && line_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                write_req = 1'b1;
                if (ace_ready) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                read_req = 1'b1;
                if (ace_ready) begin
                    // Refilled line arrives clean and shared (ReadShared).
                    tag_we     = 1'b1;
                    data_we    = 1'b1;
                    fill_sel   = 1'b1;
                    state_we   = 1'b1;
                    new_shared = 1'b1;
                    state_d    = COMPARE;
                end
            end
            UPGRADE: begin
                invalid_req = 1'b1;
                if (ace_ready) begin
                    state_we  = 1'b1;
                    new_dirty = line_dirty;
                    state_d   = COMPARE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic first_q;
    logic first_cmp;
    logic hit_path;

    // Marks the first COMPARE of a request so retries after ACE traffic are not counted again.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b0;
        end else if ((state_q == IDLE) && cpu_req_valid) begin
            first_q <= 1'b1;
        end else if (state_q == COMPARE) begin
            first_q <= 1'b0;
        end
    end

    // A hit counts only when it completes without needing an upgrade.
    assign first_cmp = (state_q == COMPARE) && first_q;
    assign hit_path  = hit && !(wr_q && line_shared);

    cache_perf_counter #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .en  (first_cmp && hit_path),
        .cnt (hit_cnt)
    );

    cache_perf_counter #(.W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .en  (first_cmp && !hit_path),
        .cnt (miss_cnt)
    );
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller with a transaction-level reference of the cache line and ACE traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_controller;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Bit positions of the packed output vector.
    localparam int O_RDY  = 9;
    localparam int O_RD   = 8;
    localparam int O_WR   = 7;
    localparam int O_INV  = 6;
    localparam int O_TAG  = 5;
    localparam int O_DATA = 4;
    localparam int O_FILL = 3;
    localparam int O_STW  = 2;
    localparam int O_ND   = 1;
    localparam int O_NS   = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_valid, cpu_req_wr, cpu_ready;
    logic          hit, line_valid, line_dirty, line_shared;
    logic          read_req, write_req, invalid_req, ace_ready;
    logic          tag_we, data_we, fill_sel, state_we, new_dirty, new_shared;
    logic [CW-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_controller #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_wr    (cpu_req_wr),
        .cpu_ready     (cpu_ready),
        .hit           (hit),
        .line_valid    (line_valid),
        .line_dirty    (line_dirty),
        .line_shared   (line_shared),
        .read_req      (read_req),
        .write_req     (write_req),
        .invalid_req   (invalid_req),
        .ace_ready     (ace_ready),
        .tag_we        (tag_we),
        .data_we       (data_we),
        .fill_sel      (fill_sel),
        .state_we      (state_we),
        .new_dirty     (new_dirty),
        .new_shared    (new_shared),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    typedef struct {
        logic       rst, v, w, h, lv, ld, ls, a, st;
        logic [9:0] exp;
        int         hcnt, mcnt;
    } cyc_t;

    cyc_t script[$];
    int   lat_q[$];

    // Reference cache line: present/shared/dirty for the addressed line, valid/dirty for the victim.
    logic p, s, d, vv, vd;
    int   m_hit = 0, m_miss = 0;
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, t0 = 0;
    bit   busy = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [9:0] outs();
        return {cpu_ready, read_req, write_req, invalid_req, tag_we,
                data_we, fill_sel, state_we, new_dirty, new_shared};
    endfunction

    function automatic cyc_t mk(input logic r, v, w, h, lv, ld, ls, a,
                                input logic [9:0] e, input logic st);
        cyc_t c;
        c.rst = r; c.v = v; c.w = w; c.h = h; c.lv = lv; c.ld = ld; c.ls = ls;
        c.a = a; c.exp = e; c.st = st;
`ifdef CACHE_PERF_CNT_EN
        c.hcnt = m_hit;
        c.mcnt = m_miss;
`else
        c.hcnt = 0;
        c.mcnt = 0;
`endif
        return c;
    endfunction

    function automatic void push_idle();
        script.push_back(mk(0, 0, rb(), rb(), rb(), rb(), rb(), rb(), '0, 0));
    endfunction

    // One ACE transaction of a random length; returns the cycles it adds to the request latency.
    function automatic int ace_phase(input int kind, input logic wr);
        int         a;
        logic       last;
        logic       ld;
        logic [9:0] e;
        a = $urandom_range(1, 4);
        for (int i = 0; i < a; i++) begin
            last = (i == a - 1);
            e = '0;
            e[kind] = 1'b1;
            ld = (kind == O_INV) ? d : rb();
            if (last && kind == O_RD) begin
                e[O_TAG] = 1'b1; e[O_DATA] = 1'b1; e[O_FILL] = 1'b1;
                e[O_STW] = 1'b1; e[O_NS] = 1'b1;
            end
            if (last && kind == O_INV) begin
                e[O_STW] = 1'b1; e[O_ND] = d;
            end
            script.push_back(mk(0, 1, wr, rb(), rb(), ld, rb(), last, e, 0));
        end
        return a + ((kind == O_WR) ? 0 : 1);
    endfunction

    // Expand one CPU request into its expected cycle trace from the cache-line rules.
    function automatic void gen_txn(input logic wr);
        logic [9:0] e;
        bit         done;
        bit         first;
        int         lat;
        done = 0; first = 1; lat = 2;
        script.push_back(mk(0, 1, wr, rb(), rb(), rb(), rb(), rb(), '0, 1));
        while (!done) begin
            e = '0;
            if (p && !(wr && s)) begin
                done = 1;
                e[O_RDY] = 1'b1;
                if (wr) begin
                    e[O_DATA] = 1'b1; e[O_STW] = 1'b1; e[O_ND] = 1'b1;
                end
            end
            script.push_back(mk(0, 1, wr, p, vv, p ? d : vd, p ? s : rb(), rb(), e, 0));
            if (first) begin
                first = 0;
                if (done) begin
                    if (m_hit < CMAX) m_hit++;
                end else begin
                    if (m_miss < CMAX) m_miss++;
                end
            end
            if (done) begin
                if (wr) d = 1'b1;
            end else if (p) begin
                lat += ace_phase(O_INV, wr);
                s = 1'b0;
            end else begin
                if (vv && vd) lat += ace_phase(O_WR, wr);
                lat += ace_phase(O_RD, wr);
                p = 1'b1; s = 1'b1; d = 1'b0;
            end
        end
        lat_q.push_back(lat);
    endfunction

    // Play queued cycles: drive after the rising edge, compare on the falling edge.
    task automatic run_script();
        cyc_t c;
        while (script.size() > 0) begin
            c = script.pop_front();
            @(posedge clk);
            #1;
            rst = c.rst; cpu_req_valid = c.v; cpu_req_wr = c.w; hit = c.h;
            line_valid = c.lv; line_dirty = c.ld; line_shared = c.ls; ace_ready = c.a;
            cyc++;
            if (c.st) begin
                t0 = cyc;
                busy = 1;
            end
            @(negedge clk);
            chk("outputs", 32'(outs()), 32'(c.exp));
            chk("hit_cnt", 32'(hit_cnt), 32'(c.hcnt));
            chk("miss_cnt", 32'(miss_cnt), 32'(c.mcnt));
            if (busy && cpu_ready) begin
                busy = 0;
                if (lat_q.size() > 0) chk("latency", 32'(cyc - t0 + 1), 32'(lat_q.pop_front()));
            end
        end
    endtask

    initial begin
        int gap;
        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_wr = 1'b0; hit = 1'b0;
        line_valid = 1'b0; line_dirty = 1'b0; line_shared = 1'b0; ace_ready = 1'b0;
        p = 1'b0; s = 1'b0; d = 1'b0; vv = 1'b0; vd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'd0);
        chk("reset_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("reset_miss_cnt", 32'(miss_cnt), 32'd0);

        // Random requests; half the time the next request targets a different line.
        for (int t = 0; t < 150; t++) begin
            if (rb()) begin
                p = rb(); s = rb(); d = rb(); vv = rb(); vd = rb();
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) push_idle();
            gen_txn(rb());
            run_script();
        end

        // Reset while a refill is outstanding, then a stray ace_ready.
        p = 1'b0; vv = 1'b0;
        script.push_back(mk(0, 1, 0, rb(), rb(), rb(), rb(), 0, '0, 0));
        script.push_back(mk(0, 1, 0, 0, 0, rb(), rb(), 0, '0, 0));
        if (m_miss < CMAX) m_miss++;
        script.push_back(mk(1, 1, 0, rb(), rb(), rb(), rb(), 0, 10'(1 << O_RD), 0));
        m_hit = 0; m_miss = 0;
        script.push_back(mk(0, 0, 0, rb(), rb(), rb(), rb(), 1, '0, 0));
        script.push_back(mk(0, 0, 0, rb(), rb(), rb(), rb(), 1, '0, 0));
        run_script();
        busy = 0;

        // Twenty load hits drive the hit counter into saturation.
        p = 1'b1;
        for (int t = 0; t < 20; t++) begin
            gen_txn(1'b0);
            run_script();
        end
        push_idle();
        run_script();
`ifdef CACHE_PERF_CNT_EN
        chk("sat_hit_cnt", 32'(hit_cnt), 32'(CMAX));
`else
        chk("sat_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
        chk("lat_pending", 32'(lat_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
